// File: rtl/light_dance_pkg.sv
// Shared types and widths for the LightDance feeder slice.
package light_dance_pkg;

  localparam int unsigned LD_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    FILL
  } ld_state_t;

endpackage

// File: rtl/ld_byte_buf.sv
// One-entry holding register between the pattern handshake and the serializer.
module ld_byte_buf
  import light_dance_pkg::*;
(
  input  logic            clk,
  input  logic            arst,
  input  logic            wr,
  input  logic            rd,
  input  logic [LD_W-1:0] wdata,
  output logic            full,
  output logic [LD_W-1:0] data
);

  // A write in the same cycle as a drain leaves the entry full with the new byte.
  always_ff @(posedge clk) begin
    if (!arst) begin
      full <= 1'b0;
      data <= '0;
    end else if (wr) begin
      full <= 1'b1;
      data <= wdata;
    end else if (rd) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/light_dance_feeder.sv
// Seed-load and MSB-first bit serializer feeding the LightDance shift/XOR register.
module light_dance_feeder
  import light_dance_pkg::*;
#(
  parameter logic        FILL_BIT = 1'b0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             seed_valid,
  input  logic [LD_W-1:0]  seed_data,
  output logic             seed_ready,
  input  logic             pat_valid,
  input  logic [LD_W-1:0]  pat_data,
  output logic             pat_ready,
  input  logic             stop,
  output logic             load,
  output logic [LD_W-1:0]  pdata,
  output logic             din,
  output logic             busy,
  output logic [CNT_W-1:0] bytes_sent,
  output logic [CNT_W-1:0] underrun_cnt
);

  ld_state_t       state;
  logic [LD_W-1:0] sreg;
  logic [2:0]      idx;
  logic            stop_l;
  logic            buf_full;
  logic [LD_W-1:0] buf_data;
  logic            buf_wr;
  logic            buf_rd;
  logic            pat_hs;
  logic            bypass;
  logic            stop_any;
  logic [LD_W-1:0] nxt_byte;
  logic [CNT_W-1:0] under_inc;

  ld_byte_buf u_buf (
    .clk   (clk),
    .arst  (arst),
    .wr    (buf_wr),
    .rd    (buf_rd),
    .wdata (pat_data),
    .full  (buf_full),
    .data  (buf_data)
  );

  assign stop_any   = stop | stop_l;
  assign nxt_byte   = buf_full ? buf_data : pat_data;
  assign seed_ready = (state == IDLE);
  assign under_inc  = (underrun_cnt == '1) ? underrun_cnt : underrun_cnt + CNT_W'(1);

  // Every exit to IDLE drains the buffer as well, so flushes share the drain path;
  // an empty buffer at a byte boundary takes the incoming byte straight into sreg.
  always_comb begin
    buf_rd = 1'b0;
    bypass = 1'b0;
    unique case (state)
      LOAD:    buf_rd = buf_full;
      SHIFT:   buf_rd = buf_full && (idx == 3'd0);
      FILL:    buf_rd = buf_full;
      default: buf_rd = 1'b0;
    endcase
    pat_ready = !buf_full || buf_rd;
    pat_hs    = pat_valid && pat_ready;
    unique case (state)
      SHIFT:   bypass = (idx == 3'd0) && !stop_any && !buf_full && pat_hs;
      FILL:    bypass = !stop && !buf_full && pat_hs;
      default: bypass = 1'b0;
    endcase
    buf_wr = pat_hs && !bypass;
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      state        <= IDLE;
      sreg         <= '0;
      idx          <= '0;
      stop_l       <= 1'b0;
      load         <= 1'b0;
      pdata        <= '0;
      din          <= 1'b0;
      busy         <= 1'b0;
      bytes_sent   <= '0;
      underrun_cnt <= '0;
    end else begin
      load <= 1'b0;
      unique case (state)
        IDLE: begin
          stop_l <= 1'b0;
          if (seed_valid) begin
            state <= LOAD;
            load  <= 1'b1;
            pdata <= seed_data;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            din   <= FILL_BIT;
          end else if (buf_full) begin
            state <= SHIFT;
            sreg  <= buf_data;
            din   <= buf_data[LD_W-1];
            idx   <= 3'd7;
          end else begin
            state        <= FILL;
            din          <= FILL_BIT;
            underrun_cnt <= under_inc;
          end
        end
        SHIFT: begin
          if (stop) stop_l <= 1'b1;
          if (idx != 3'd0) begin
            din <= sreg[idx - 3'd1];
            idx <= idx - 3'd1;
          end else begin
            bytes_sent <= bytes_sent + CNT_W'(1);
            if (stop_any) begin
              state  <= IDLE;
              busy   <= 1'b0;
              din    <= FILL_BIT;
              stop_l <= 1'b0;
            end else if (buf_full || pat_hs) begin
              sreg <= nxt_byte;
              din  <= nxt_byte[LD_W-1];
              idx  <= 3'd7;
            end else begin
              state        <= FILL;
              din          <= FILL_BIT;
              underrun_cnt <= under_inc;
            end
          end
        end
        FILL: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            din   <= FILL_BIT;
          end else if (buf_full || pat_hs) begin
            state <= SHIFT;
            sreg  <= nxt_byte;
            din   <= nxt_byte[LD_W-1];
            idx   <= 3'd7;
          end else begin
            din          <= FILL_BIT;
            underrun_cnt <= under_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
